// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                  input  dm_ack, dm_rdata);
  modport slave  (input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                  output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues data-memory accesses, waits for ack with a bounded timeout,
// aligns/extends load data and registers the MEM/WB payload.
module mem_stage #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alures_in,
  input  logic [31:0] rs2_data_in,
  input  logic        MemWrite_in,
  input  logic        load_in,
  input  logic [2:0]  DMType_in,
  input  logic        RegWrite_in,
  input  logic [1:0]  WDSel_in,
  input  logic        INT,
  mem_stage_if.master dm,
  output logic        stall,
  output logic [31:0] PC_out,
  output logic [4:0]  rd_out,
  output logic [31:0] wdata_out,
  output logic        RegWrite_out,
  output logic        valid_out,
  output logic        misalign_out,
  output logic        timeout_out
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t        state, state_nx;
  size_t         size;
  logic [CW-1:0] wait_cnt;
  logic          int_pend;
  logic [1:0]    acc_lo;
  logic [2:0]    acc_type;

  logic        mem_op, aligned, stall_c, start, upd, upd_rw, rw_val;
  logic        valid_nx, mis_nx, to_nx;
  logic [31:0] rd_shift, load_ext, wd_sel;

  assign mem_op = load_in | MemWrite_in;

  always_comb begin
    unique case (DMType_in)
      3'b001, 3'b010: size = SZ_HALF;
      3'b011, 3'b100: size = SZ_BYTE;
      default:        size = SZ_WORD;
    endcase
  end

  assign aligned = (size == SZ_BYTE) ||
                   (size == SZ_HALF && !alures_in[0]) ||
                   (size == SZ_WORD && alures_in[1:0] == 2'b00);

  // Load lane is taken from the address/type captured when the access started.
  assign rd_shift = dm.dm_rdata >> {acc_lo, 3'b000};
  always_comb begin
    unique case (acc_type)
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  load_ext = {16'h0000, rd_shift[15:0]};
      3'b011:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_ext = {24'h000000, rd_shift[7:0]};
      default: load_ext = dm.dm_rdata;
    endcase
  end

  always_comb begin
    unique case (WDSel_in)
      2'b01:   wd_sel = load_ext;
      2'b10:   wd_sel = PC_in + 32'd4;
      default: wd_sel = alures_in;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nx = state;
    stall_c  = 1'b0;
    start    = 1'b0;
    upd      = 1'b0;
    upd_rw   = 1'b0;
    rw_val   = 1'b0;
    valid_nx = 1'b0;
    mis_nx   = 1'b0;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (INT) begin
          upd_rw = 1'b1;
        end else if (!mem_op) begin
          upd      = 1'b1;
          upd_rw   = 1'b1;
          rw_val   = RegWrite_in;
          valid_nx = 1'b1;
        end else if (!aligned) begin
          upd      = 1'b1;
          upd_rw   = 1'b1;
          valid_nx = 1'b1;
          mis_nx   = 1'b1;
        end else begin
          start    = 1'b1;
          stall_c  = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (dm.dm_ack || wait_cnt == CW'(WAIT_MAX - 1)) begin
          state_nx = IDLE;
          stall_c  = 1'b0;
          upd_rw   = 1'b1;
          // A squashed instruction retires as a bubble whether it completed or timed out.
          if (!(int_pend || INT)) begin
            upd      = 1'b1;
            valid_nx = 1'b1;
            rw_val   = dm.dm_ack & RegWrite_in;
            to_nx    = !dm.dm_ack;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign stall     = stall_c & rst;
  assign dm.dm_req = (state == ACCESS) & rst;

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every register here, including the captured request bus.
    if (!rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      int_pend     <= 1'b0;
      acc_lo       <= 2'b00;
      acc_type     <= 3'b000;
      dm.dm_we     <= 1'b0;
      dm.dm_addr   <= '0;
      dm.dm_be     <= '0;
      dm.dm_wdata  <= '0;
      PC_out       <= '0;
      rd_out       <= '0;
      wdata_out    <= '0;
      RegWrite_out <= 1'b0;
      valid_out    <= 1'b0;
      misalign_out <= 1'b0;
      timeout_out  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nx;
      if (start) begin
        wait_cnt    <= '0;
        int_pend    <= 1'b0;
        acc_lo      <= alures_in[1:0];
        acc_type    <= DMType_in;
        dm.dm_we    <= MemWrite_in;
        dm.dm_addr  <= {alures_in[31:2], 2'b00};
        unique case (size)
          SZ_BYTE: begin
            dm.dm_be    <= 4'b0001 << alures_in[1:0];
            dm.dm_wdata <= {4{rs2_data_in[7:0]}};
          end
          SZ_HALF: begin
            dm.dm_be    <= alures_in[1] ? 4'b1100 : 4'b0011;
            dm.dm_wdata <= {2{rs2_data_in[15:0]}};
          end
          default: begin
            dm.dm_be    <= 4'b1111;
            dm.dm_wdata <= rs2_data_in;
          end
        endcase
      end else if (state == ACCESS) begin
        wait_cnt <= wait_cnt + CW'(1);
        if (INT) int_pend <= 1'b1;
      end
      if (upd) begin
        PC_out    <= PC_in;
        rd_out    <= rd_in;
        wdata_out <= wd_sel;
      end
      if (upd_rw) RegWrite_out <= rw_val;
      valid_out    <= valid_nx;
      misalign_out <= mis_nx;
      timeout_out  <= to_nx;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads/stores, misalignment,
// timeout, flush and reset behaviour.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_in, alures_in, rs2_data_in;
  logic [4:0]  rd_in;
  logic        MemWrite_in, load_in, RegWrite_in, INT;
  logic [2:0]  DMType_in;
  logic [1:0]  WDSel_in;
  logic        stall, RegWrite_out, valid_out, misalign_out, timeout_out;
  logic [31:0] PC_out, wdata_out;
  logic [4:0]  rd_out;

  int total = 0;
  int bad   = 0;

  mem_stage_if dmb ();

  mem_stage #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst),
    .PC_in(PC_in), .rd_in(rd_in), .alures_in(alures_in), .rs2_data_in(rs2_data_in),
    .MemWrite_in(MemWrite_in), .load_in(load_in), .DMType_in(DMType_in),
    .RegWrite_in(RegWrite_in), .WDSel_in(WDSel_in), .INT(INT),
    .dm(dmb.master), .stall(stall),
    .PC_out(PC_out), .rd_out(rd_out), .wdata_out(wdata_out), .RegWrite_out(RegWrite_out),
    .valid_out(valid_out), .misalign_out(misalign_out), .timeout_out(timeout_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    load_in = 1'b0; MemWrite_in = 1'b0; INT = 1'b0; WDSel_in = 2'b00;
    RegWrite_in = 1'b0; DMType_in = 3'b000; alures_in = 32'h0; rd_in = 5'd0;
  endtask

  task automatic set_mem(input logic [31:0] addr, input logic [2:0] ty, input logic st,
                         input logic [31:0] rs2);
    alures_in = addr; DMType_in = ty; MemWrite_in = st; load_in = !st;
    rs2_data_in = rs2; WDSel_in = st ? 2'b00 : 2'b01; RegWrite_in = !st; rd_in = 5'd9;
  endtask

  // Full access with ack in the lat-th ACCESS cycle; stall must be high for exactly lat cycles.
  task automatic run_mem(input string tag, input logic [31:0] addr, input logic [2:0] ty,
                         input logic st, input logic [31:0] rs2, input logic [31:0] rdata,
                         input int lat, input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] res);
    int hi = 0;
    set_mem(addr, ty, st, rs2);
    dmb.dm_rdata = rdata;
    #1;
    if (stall) hi++;
    check({tag, "_req_idle"}, 32'(dmb.dm_req), 32'd0);
    step();
    check({tag, "_addr"}, dmb.dm_addr, {addr[31:2], 2'b00});
    check({tag, "_be"}, 32'(dmb.dm_be), 32'(be));
    check({tag, "_we"}, 32'(dmb.dm_we), 32'(st));
    if (st) check({tag, "_wdata"}, dmb.dm_wdata, wd);
    for (int i = 1; i < lat; i++) begin
      if (stall) hi++;
      check({tag, "_req_wait"}, 32'(dmb.dm_req), 32'd1);
      step();
    end
    dmb.dm_ack = 1'b1;
    #1;
    check({tag, "_stall_ack"}, 32'(stall), 32'd0);
    check({tag, "_stall_cycles"}, 32'(hi), 32'(lat));
    step();
    dmb.dm_ack = 1'b0;
    set_nop();
    check({tag, "_valid"}, 32'(valid_out), 32'd1);
    check({tag, "_regwrite"}, 32'(RegWrite_out), 32'(!st));
    if (!st) check({tag, "_result"}, wdata_out, res);
    check({tag, "_req_after"}, 32'(dmb.dm_req), 32'd0);
  endtask

  initial begin
    int n;
    logic last_stall;
    rst = 1'b0;
    PC_in = 32'h0; rs2_data_in = 32'h0;
    dmb.dm_ack = 1'b0; dmb.dm_rdata = 32'h0;
    set_nop();
    // Aligned load presented during reset must not request or stall
    set_mem(32'h100, 3'b000, 1'b0, 32'h0);
    step();
    step();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dmb.dm_req), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_wdata", wdata_out, 32'd0);
    check("rst_regwrite", 32'(RegWrite_out), 32'd0);
    set_nop();
    rst = 1'b1;

    // ALU result pass-through
    PC_in = 32'h40; alures_in = 32'h1234; rd_in = 5'd5; RegWrite_in = 1'b1; WDSel_in = 2'b00;
    #1;
    check("alu_stall", 32'(stall), 32'd0);
    step();
    check("alu_wdata", wdata_out, 32'h1234);
    check("alu_rd", 32'(rd_out), 32'd5);
    check("alu_valid", 32'(valid_out), 32'd1);
    check("alu_regwrite", 32'(RegWrite_out), 32'd1);
    check("alu_pc", PC_out, 32'h40);
    PC_in = 32'h100; WDSel_in = 2'b10; rd_in = 5'd1;
    step();
    check("link_wdata", wdata_out, 32'h104);
    WDSel_in = 2'b11; alures_in = 32'hCAFE;
    step();
    check("sel11_wdata", wdata_out, 32'hCAFE);

    // Flush in IDLE: bubble, no request even with a load presented
    set_mem(32'h100, 3'b000, 1'b0, 32'h0);
    INT = 1'b1;
    #1;
    check("int_idle_stall", 32'(stall), 32'd0);
    step();
    check("int_idle_req", 32'(dmb.dm_req), 32'd0);
    check("int_idle_valid", 32'(valid_out), 32'd0);
    check("int_idle_regwrite", 32'(RegWrite_out), 32'd0);
    check("int_idle_pc_hold", PC_out, 32'h100);
    set_nop();
    step();

    PC_in = 32'h200;
    run_mem("lb",  32'h103, 3'b011, 1'b0, 32'h0, 32'h80FF_FF7F, 3, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_mem("lhu", 32'h102, 3'b010, 1'b0, 32'h0, 32'h80FF_FF7F, 1, 4'b1100, 32'h0, 32'h0000_80FF);
    run_mem("lh",  32'h100, 3'b001, 1'b0, 32'h0, 32'h0000_8001, 1, 4'b0011, 32'h0, 32'hFFFF_8001);
    run_mem("lw",  32'h104, 3'b000, 1'b0, 32'h0, 32'hDEAD_BEEF, 2, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    run_mem("sh",  32'h202, 3'b001, 1'b1, 32'hABCD_1234, 32'h0, 1, 4'b1100, 32'h1234_1234, 32'h0);
    run_mem("sb",  32'h201, 3'b011, 1'b1, 32'h0000_005A, 32'h0, 2, 4'b0010, 32'h5A5A_5A5A, 32'h0);

    // Misaligned word and half
    set_mem(32'h101, 3'b000, 1'b0, 32'h0);
    #1;
    check("mis_w_stall", 32'(stall), 32'd0);
    step();
    set_nop();
    check("mis_w_req", 32'(dmb.dm_req), 32'd0);
    check("mis_w_flag", 32'(misalign_out), 32'd1);
    check("mis_w_regwrite", 32'(RegWrite_out), 32'd0);
    check("mis_w_valid", 32'(valid_out), 32'd1);
    step();
    check("mis_w_pulse", 32'(misalign_out), 32'd0);
    set_mem(32'h203, 3'b001, 1'b0, 32'h0);
    step();
    set_nop();
    check("mis_h_flag", 32'(misalign_out), 32'd1);

    // Timeout: ack never arrives
    set_mem(32'h300, 3'b000, 1'b0, 32'h0);
    #1;
    n = 0;
    last_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!dmb.dm_req) break;
      n++;
      last_stall = stall;
    end
    check("to_req_cycles", 32'(n), 32'd15);
    check("to_stall_last", 32'(last_stall), 32'd0);
    check("to_flag", 32'(timeout_out), 32'd1);
    check("to_valid", 32'(valid_out), 32'd1);
    check("to_regwrite", 32'(RegWrite_out), 32'd0);
    set_nop();
    #1;
    check("to_stall_after", 32'(stall), 32'd0);
    step();
    check("to_pulse", 32'(timeout_out), 32'd0);

    // Flush during a pending load: request held until ack, then a bubble
    set_mem(32'h400, 3'b000, 1'b0, 32'h0);
    dmb.dm_rdata = 32'h1122_3344;
    step();
    check("int_acc_req1", 32'(dmb.dm_req), 32'd1);
    step();
    INT = 1'b1;
    check("int_acc_req2", 32'(dmb.dm_req), 32'd1);
    step();
    INT = 1'b0;
    check("int_acc_req3", 32'(dmb.dm_req), 32'd1);
    step();
    dmb.dm_ack = 1'b1;
    #1;
    check("int_acc_req4", 32'(dmb.dm_req), 32'd1);
    check("int_acc_stall4", 32'(stall), 32'd0);
    step();
    dmb.dm_ack = 1'b0;
    set_nop();
    check("int_acc_valid", 32'(valid_out), 32'd0);
    check("int_acc_regwrite", 32'(RegWrite_out), 32'd0);
    check("int_acc_req_after", 32'(dmb.dm_req), 32'd0);

    // Reset in the middle of an access abandons it; a late ack is ignored
    set_mem(32'h500, 3'b000, 1'b0, 32'h0);
    step();
    check("rst_acc_req", 32'(dmb.dm_req), 32'd1);
    rst = 1'b0;
    set_nop();
    step();
    check("rst_acc_req_drop", 32'(dmb.dm_req), 32'd0);
    check("rst_acc_valid", 32'(valid_out), 32'd0);
    rst = 1'b1;
    alures_in = 32'h77;
    dmb.dm_ack = 1'b1;
    #1;
    check("rst_acc_stall", 32'(stall), 32'd0);
    step();
    dmb.dm_ack = 1'b0;
    check("rst_acc_wdata", wdata_out, 32'h77);
    check("rst_acc_req_idle", 32'(dmb.dm_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter WAIT_MAX, default 15, SHALL be the maximum number of cycles to wait for dm_ack before an access is aborted.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be a synchronous, active-low reset.
REQ-004 PC_in in 32, rd_in in 5, alures_in in 32, rs2_data_in in 32 SHALL be the instruction fields from the EX/MEM register.
REQ-005 MemWrite_in in 1, load_in in 1, DMType_in in 3, RegWrite_in in 1, WDSel_in in 2 SHALL be the EX/MEM control signals.
REQ-006 INT  in  1  SHALL be the flush request; it squashes the current instruction.
REQ-007 dm_req out 1, dm_we out 1, dm_addr out 32, dm_be out 4, dm_wdata out 32 SHALL form the data-memory request bus.
REQ-008 dm_ack in 1, dm_rdata in 32 SHALL form the data-memory response.
REQ-009 stall  out  1  SHALL, when high, require upstream stages and EX/MEM to hold.
REQ-010 PC_out out 32, rd_out out 5, wdata_out out 32, RegWrite_out out 1, valid_out out 1 SHALL be the registered MEM/WB payload.
REQ-011 misalign_out out 1, timeout_out out 1 SHALL be registered single-cycle error pulses.

Function
REQ-012 DMType encoding SHALL be: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned; other codes SHALL be treated as word.
REQ-013 WDSel encoding SHALL be: 00 alures_in, 01 extended load data, 10 PC_in+4; 11 SHALL select alures_in.
REQ-014 The FSM SHALL have two states, IDLE and ACCESS, and SHALL enter IDLE on reset.
REQ-015 IDLE, with no memory op (load_in=0 and MemWrite_in=0): the payload SHALL be registered next cycle with valid_out=1, and stall SHALL be 0.
REQ-016 IDLE, with a memory op and an aligned address: the FSM SHALL go to ACCESS, and stall SHALL be 1 combinationally in that same cycle.
REQ-017 Alignment rules: word requires addr[1:0]=0; half requires addr[0]=0; byte is always aligned.
REQ-018 A misaligned op SHALL issue no request and SHALL register misalign_out=1, RegWrite_out=0, valid_out=1 next cycle, with no stall.
REQ-019 In ACCESS, dm_req SHALL stay 1 and dm_addr, dm_we, dm_be, dm_wdata SHALL stay stable until dm_ack; stall SHALL stay 1.
REQ-020 dm_addr SHALL be {alures_in[31:2], 2'b00}.
REQ-021 dm_be SHALL be 1111 for word, 0011<<addr[1] x2 for half, and 0001<<addr[1:0] for byte.
REQ-022 dm_wdata SHALL be rs2_data_in replicated: byte into all 4 lanes, half into both lanes, word unchanged.
REQ-023 On dm_ack in ACCESS: the payload SHALL be registered in the ack cycle, the load lane SHALL be extracted by addr[1:0] and sign- or zero-extended per DMType, and the FSM SHALL return to IDLE; stall SHALL be 0 in the ack cycle.
REQ-024 A stores SHALL register RegWrite_out=RegWrite_in, normally 0.
REQ-025 A wait counter SHALL clear on entry to ACCESS and increment each cycle without ack.
REQ-026 On reaching WAIT_MAX the FSM SHALL drop dm_req, return to IDLE, and register timeout_out=1, RegWrite_out=0, valid_out=1.
REQ-027 INT in IDLE SHALL register a bubble next cycle (valid_out=0, RegWrite_out=0) and issue no request.
REQ-028 INT in ACCESS SHALL keep dm_req until ack or timeout, then register a bubble instead of the result.
REQ-029 When no update is due, all payload outputs SHALL hold, except valid_out, misalign_out and timeout_out, which SHALL fall to 0.

Reset
REQ-030 With rst=0 at a rising edge, the FSM SHALL go to IDLE, the wait counter SHALL clear, and every output register SHALL be 0; dm_req and stall SHALL be 0 while rst=0.
REQ-031 Reset during ACCESS SHALL abandon the access immediately, dropping dm_req in the cycle after the edge; any later dm_ack SHALL be ignored.

Verification
REQ-032 Scenario: ALU op, alures=0x1234, WDSel=00, RegWrite=1, rd=5 -> next cycle wdata_out=0x1234, rd_out=5, valid_out=1, stall never 1.
REQ-033 Scenario: lb at addr 0x103, DMType=011, dm_rdata=0x80FF_FF7F, ack after 3 cycles -> dm_be=1000, stall high 3 cycles, wdata_out=0xFFFF_FF80.
REQ-034 Scenario: sh at addr 0x202, rs2_data=0xABCD_1234 -> dm_addr=0x200, dm_be=1100, dm_wdata=0x1234_1234, dm_we=1.
REQ-035 Scenario: lw at addr 0x101 -> no dm_req, misalign_out=1 for one cycle, RegWrite_out=0.
REQ-036 Scenario: lw with dm_ack never asserted -> after 15 cycles dm_req=0, timeout_out=1, stall=0.
REQ-037 Scenario: INT asserted in cycle 2 of a pending lw, ack in cycle 4 -> dm_req held through cycle 4, then valid_out=0, RegWrite_out=0.
